fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage directly downstream of `ProgramCounter`. It consumes the current PC and issues an instruction-memory read with a req/ack handshake. It captures the returned word into the IF/ID pipeline register and drives `ProgramCounter`'s write-enable and next-PC inputs. It handles ID back-pressure (stall), variable memory latency and branch/jump redirects, including a redirect that arrives while a memory read is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: value of `id_pc` and `pc_next` while in reset.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-low reset (sampled on posedge `clk`; 0 = reset).
- `pc_in`  in  32  current PC from `ProgramCounter`.
- `pc_write`  out  1  advance `ProgramCounter` this cycle (combinational).
- `pc_next`  out  32  value for `ProgramCounter` to load when `pc_write`=1.
- `redirect`  in  1  one-cycle branch/jump request from a later stage.
- `redirect_target`  in  32  new PC, valid with `redirect`.
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  `{pc_in[31:2],2'b00}`.
- `imem_ack`  in  1  read data valid; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `id_stall`  in  1  ID cannot accept a new instruction.
- `id_valid`  out  1  IF/ID register holds a valid instruction.
- `id_instr`  out  32  captured instruction.
- `id_pc`  out  32  PC of `id_instr`.
- `id_pc_plus4`  out  32  `id_pc + 4`, modulo 2^32.

## Operation
- FSM states: IDLE, REQ, HOLD. Additional state: 32-bit `hold_buf`, `redir_pending` flag, 32-bit `redir_tgt`.
- Reset values:
  - State = IDLE; `redir_pending` = 0.
  - `id_valid` = 0; `id_instr` = 0; `id_pc` = `RESET_PC`; `id_pc_plus4` = `RESET_PC` + 4.
  - Outputs during reset: `imem_req` = 0, `pc_write` = 0.
- IDLE: `imem_req` = 0. Transitions to REQ on the next edge. If `redirect` is asserted here, it is applied immediately: `pc_write` = 1, `pc_next` = `redirect_target`.
- REQ: `imem_req` = 1. `pc_in` is stable because `pc_write` = 0 until ack. On `imem_ack`:
  - Response discarded (`redir_pending` = 1, or `redirect` asserted this same cycle): `pc_write` = 1, `pc_next` = latest target (`redirect_target` takes priority over `redir_tgt`). Clear `redir_pending`; `id_valid` -> 0; stay in REQ.
  - Slot free (`!id_valid || !id_stall`): load the IF/ID register with {`imem_rdata`, `pc_in`, `pc_in`+4}, `id_valid` -> 1. Drive `pc_write` = 1, `pc_next` = `pc_in`+4. Stay in REQ.
  - Slot busy: `hold_buf` <= `imem_rdata`; `pc_write` = 0; go to HOLD.
- Redirect in REQ without ack: `redir_pending` <= 1, `redir_tgt` <= `redirect_target`; `id_valid` -> 0 (flush). The outstanding read completes later and its data is dropped. If a second redirect arrives while one is pending, the latest target wins.
- HOLD: `imem_req` = 0.
  - When `id_stall` = 0: move `hold_buf` into IF/ID with `pc_in`/`pc_in`+4; `pc_write` = 1, `pc_next` = `pc_in`+4; go to REQ.
  - When `redirect` = 1: discard `hold_buf`, `id_valid` -> 0, `pc_write` = 1, `pc_next` = `redirect_target`; go to REQ.
- Redirect always flushes `id_valid` at the same edge, regardless of `id_stall`.
- When `id_valid` = 1 and `id_stall` = 1, `id_*` outputs hold their values.
- Mid-operation reset: all state is discarded, including any outstanding ack; the ack value is ignored in the reset cycle. Outputs return to their reset values on that edge.

## Timing
- `pc_write`, `pc_next`, `imem_req` and `imem_addr` are combinational from state and inputs. `id_*` outputs are registered.
- Zero-wait memory (ack in the same cycle as req) sustains 1 instruction per cycle.
- `id_*` outputs update on the edge where ack is accepted.
- With memory latency N cycles, each fetch occupies N+1 cycles in REQ.
- The first request after reset release is issued 1 cycle later (IDLE -> REQ).
- Redirect penalty: the next fetch uses the target on the cycle after the redirect (or after the pending ack). There is no wrong-path instruction ever seen with `id_valid` = 1.
- `pc_write` is asserted for exactly one cycle per accepted or redirected fetch.

## Test plan
- Reset, zero-wait memory, `pc_in` fed back from `ProgramCounter` starting at 0: `id_pc` = 0, 4, 8, 12 on consecutive edges, with `id_instr` matching memory.
- Memory latency 3: `imem_req` stays high for 4 cycles per fetch, `imem_addr` is stable across them, and `pc_write` pulses only on the ack cycle.
- `id_stall` = 1 for 3 cycles with `id_valid` = 1: `id_*` are unchanged, the block sits in HOLD with `imem_req` = 0, and the next instruction appears on the edge after the stall drops, with no loss or duplication.
- Redirect to 0x100 while a latency-3 read of 0x8 is outstanding: `id_valid` drops, the 0x8 data is never presented, `pc_next` = 0x100 on that ack, and the next `id_pc` = 0x100.
- Redirect in the same cycle as ack, followed by a second redirect (0x200 then 0x300) while pending: the fetch resumes at 0x300.
- Assert `rst` = 0 during an outstanding read, with ack arriving in the reset cycle: `id_valid` = 0, `pc_write` = 0, and no capture occurs; fetch restarts 1 cycle after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues req/ack reads at pc_in, fills the IF/ID register,
// and steers ProgramCounter through pc_write/pc_next, including deferred redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_write,
  output logic [31:0] pc_next,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;

  state_t      state;
  ifid_t       ifid;
  logic [31:0] hold_buf;
  logic [31:0] redir_tgt;
  logic        redir_pending;

  logic [31:0] pc_plus4;
  logic        slot_free;
  logic        discard;

  assign pc_plus4  = pc_in + 32'd4;
  assign slot_free = !ifid.valid || !id_stall;
  assign discard   = redir_pending || redirect;
  assign imem_addr = {pc_in[31:2], 2'b00};

  assign id_valid    = ifid.valid;
  assign id_instr    = ifid.instr;
  assign id_pc       = ifid.pc;
  assign id_pc_plus4 = ifid.pc_plus4;

  always_comb begin
    pc_write = 1'b0;
    pc_next  = pc_plus4;
    imem_req = 1'b0;
    if (!rst) begin
      pc_next = RESET_PC;
    end else begin
      case (state)
        IDLE: if (redirect) begin
          pc_write = 1'b1;
          pc_next  = redirect_target;
        end
        // pc_in must stay put while a read is in flight, so redirects here are deferred
        REQ: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (discard) begin
              pc_write = 1'b1;
              pc_next  = redirect ? redirect_target : redir_tgt;
            end else if (slot_free) begin
              pc_write = 1'b1;
            end
          end
        end
        HOLD: if (redirect) begin
          pc_write = 1'b1;
          pc_next  = redirect_target;
        end else if (!id_stall) begin
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      redir_pending <= 1'b0;
      redir_tgt     <= RESET_PC;
      hold_buf      <= 32'h0;
      ifid          <= '{valid: 1'b0, instr: 32'h0, pc: RESET_PC, pc_plus4: RESET_PC + 32'd4};
    end else begin
      // ID took the instruction; leave a bubble unless something new is loaded below
      if (ifid.valid && !id_stall) ifid.valid <= 1'b0;
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect) ifid.valid <= 1'b0;
        end
        REQ: begin
          if (imem_ack) begin
            if (discard) begin
              redir_pending <= 1'b0;
              ifid.valid    <= 1'b0;
            end else if (slot_free) begin
              ifid <= '{valid: 1'b1, instr: imem_rdata, pc: pc_in, pc_plus4: pc_plus4};
            end else begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end
          end else if (redirect) begin
            redir_pending <= 1'b1;
            redir_tgt     <= redirect_target;
            ifid.valid    <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            ifid.valid <= 1'b0;
            state      <= REQ;
          end else if (!id_stall) begin
            ifid  <= '{valid: 1'b1, instr: hold_buf, pc: pc_in, pc_plus4: pc_plus4};
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a ProgramCounter model and an addr-derived memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc), .pc_write(pc_write), .pc_next(pc_next),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  initial pc = 32'h0;
  always @(posedge clk) begin
    if (!rst) pc <= 32'h0;
    else if (pc_write) pc <= pc_next;
  end

  assign imem_rdata = 32'h1000_0000 + imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic stall, input logic rd, input logic [31:0] tgt);
    imem_ack = ack; id_stall = stall; redirect = rd; redirect_target = tgt;
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] p);
    chk({tag, "_valid"}, {31'h0, id_valid}, {31'h0, v});
    chk({tag, "_pc"}, id_pc, p);
    chk({tag, "_pc4"}, id_pc_plus4, p + 32'd4);
    chk({tag, "_instr"}, id_instr, 32'h1000_0000 + p);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    // reset state, ack ignored while in reset
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc_plus4, 32'h4);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_pcw", {31'h0, pc_write}, 32'h0);

    // release: one IDLE cycle without a request
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("idle_req", {31'h0, imem_req}, 32'h0);
    tick();

    // zero-wait memory: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      chk("zw_req", {31'h0, imem_req}, 32'h1);
      chk("zw_addr", imem_addr, 32'(4 * i));
      chk("zw_pcw", {31'h0, pc_write}, 32'h1);
      chk("zw_pcn", pc_next, 32'(4 * i + 4));
      tick();
      chk_id("zw", 1'b1, 32'(4 * i));
    end

    // latency 3: four REQ cycles, pc_write only on the ack cycle
    for (int c = 0; c < 4; c++) begin
      drive(c == 3, 1'b0, 1'b0, 32'h0);
      chk("lat_req", {31'h0, imem_req}, 32'h1);
      chk("lat_addr", imem_addr, 32'h10);
      chk("lat_pcw", {31'h0, pc_write}, {31'h0, c == 3});
      if (c == 3) chk("lat_pcn", pc_next, 32'h14);
      tick();
    end
    chk_id("lat", 1'b1, 32'h10);

    // stall for 3 cycles with a valid instruction: data parked in HOLD
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("st_pcw0", {31'h0, pc_write}, 32'h0);
    tick();
    chk_id("st0", 1'b1, 32'h10);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      chk("st_req", {31'h0, imem_req}, 32'h0);
      chk("st_pcw", {31'h0, pc_write}, 32'h0);
      tick();
      chk_id("st_hold", 1'b1, 32'h10);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("st_rel_req", {31'h0, imem_req}, 32'h0);
    chk("st_rel_pcw", {31'h0, pc_write}, 32'h1);
    chk("st_rel_pcn", pc_next, 32'h18);
    tick();
    chk_id("st_out", 1'b1, 32'h14);

    // reset during an outstanding read with ack in the reset cycle
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mr_req", {31'h0, imem_req}, 32'h1);
    chk("mr_addr", imem_addr, 32'h18);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mr_pcw", {31'h0, pc_write}, 32'h0);
    chk("mr_req_rst", {31'h0, imem_req}, 32'h0);
    tick();
    chk("mr_valid", {31'h0, id_valid}, 32'h0);
    chk("mr_pc", id_pc, 32'h0);
    chk("mr_pc4", id_pc_plus4, 32'h4);
    chk("mr_instr", id_instr, 32'h0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mr_idle_req", {31'h0, imem_req}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mr_restart_req", {31'h0, imem_req}, 32'h1);
    chk("mr_restart_addr", imem_addr, 32'h0);
    tick();
    chk_id("mr_f0", 1'b1, 32'h0);
    tick();
    chk_id("mr_f4", 1'b1, 32'h4);

    // redirect to 0x100 while the latency-3 read of 0x8 is outstanding
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_addr", imem_addr, 32'h8);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    chk("rd_pcw_noack", {31'h0, pc_write}, 32'h0);
    tick();
    chk("rd_flush", {31'h0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    chk("rd_wait_addr", imem_addr, 32'h8);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rd_ack_pcw", {31'h0, pc_write}, 32'h1);
    chk("rd_ack_pcn", pc_next, 32'h100);
    tick();
    chk("rd_dropped", {31'h0, id_valid}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rd_tgt_addr", imem_addr, 32'h100);
    tick();
    chk_id("rd_tgt", 1'b1, 32'h100);

    // redirect with ack (0x200), then two redirects while pending, latest wins
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    chk("r2_pcw", {31'h0, pc_write}, 32'h1);
    chk("r2_pcn", pc_next, 32'h200);
    tick();
    chk("r2_flush", {31'h0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 32'h280);
    chk("r2_addr", imem_addr, 32'h200);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h300);
    chk("r2_pcw_pend", {31'h0, pc_write}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("r2_ack_pcn", pc_next, 32'h300);
    chk("r2_ack_pcw", {31'h0, pc_write}, 32'h1);
    tick();
    chk("r2_dropped", {31'h0, id_valid}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("r2_tgt_addr", imem_addr, 32'h300);
    tick();
    chk_id("r2_tgt", 1'b1, 32'h300);

    // redirect while parked in HOLD under stall: flushes despite stall
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h400);
    chk("hr_req", {31'h0, imem_req}, 32'h0);
    chk("hr_pcw", {31'h0, pc_write}, 32'h1);
    chk("hr_pcn", pc_next, 32'h400);
    tick();
    chk("hr_flush", {31'h0, id_valid}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    chk("hr_addr", imem_addr, 32'h400);
    tick();
    chk_id("hr_tgt", 1'b1, 32'h400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
